// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge loader and bank-switch detector.
package cart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DECIDE,
    ST_FIN
  } state_t;

  typedef enum logic [3:0] {
    BS_NONE = 4'd0,
    BS_F8   = 4'd1,
    BS_F6   = 4'd2,
    BS_FE   = 4'd3,
    BS_E0   = 4'd4,
    BS_3F   = 4'd5,
    BS_F4   = 4'd6,
    BS_P2   = 4'd7,
    BS_FA   = 4'd8,
    BS_CV   = 4'd9
  } bs_t;

  localparam logic [16:0] SZ_4K     = 17'd4096;
  localparam logic [16:0] SZ_8K     = 17'd8192;
  localparam logic [16:0] SZ_P2_MIN = 17'd10240;
  localparam logic [16:0] SZ_P2_MAX = 17'd10495;
  localparam logic [16:0] SZ_12K    = 17'd12288;
  localparam logic [16:0] SZ_16K    = 17'd16384;
  localparam logic [16:0] SZ_32K    = 17'd32768;

  // 6502 opcodes and operands that make up the hotspot signatures.
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_BIT_ABS = 8'h2C;
  localparam logic [7:0] HOT_LO_MIN = 8'hE0;
  localparam logic [7:0] HOT_LO_MAX = 8'hF7;
  localparam logic [7:0] HOT_HI     = 8'h1F;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] ZP_3F      = 8'h3F;

  localparam int unsigned SC_FILL_LAST = 127;

  function automatic bs_t ext_to_bs(input logic [23:0] ext);
    bs_t bs;
    case (ext)
      ".F8":   bs = BS_F8;
      ".F6":   bs = BS_F6;
      ".FE":   bs = BS_FE;
      ".E0":   bs = BS_E0;
      ".3F":   bs = BS_3F;
      ".F4":   bs = BS_F4;
      ".P2":   bs = BS_P2;
      ".FA":   bs = BS_FA;
      ".CV":   bs = BS_CV;
      default: bs = BS_NONE;
    endcase
    return bs;
  endfunction

endpackage

// File: rtl/cart_sig_scan.sv
// Signature scanner: 3-byte window over the ROM read stream, E0/3F hotspot
// counters and the SuperChip fill check on bytes 1..127.
module cart_sig_scan
  import cart_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic [2:0]        e0_cnt,
  output logic [1:0]        c3f_cnt,
  output logic              sc_fill
);

  // Only the two previous bytes are stored; the post-shift window is
  // {w1_q, w2_q, data} with data as the newest byte.
  logic [7:0] w1_q;
  logic [7:0] w2_q;
  logic [7:0] first_byte;
  logic       e0_hit;
  logic       c3f_hit;
  logic       in_fill_range;

  always_comb begin
    e0_hit  = ((w1_q == OP_STA_ABS) || (w1_q == OP_LDA_ABS) || (w1_q == OP_BIT_ABS)) &&
              (w2_q >= HOT_LO_MIN) && (w2_q <= HOT_LO_MAX) && (data == HOT_HI);
    c3f_hit = (w2_q == OP_STA_ZP) && (data == ZP_3F);
    in_fill_range = (addr != '0) && (32'(addr) <= SC_FILL_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      w1_q       <= '0;
      w2_q       <= '0;
      first_byte <= '0;
      e0_cnt     <= '0;
      c3f_cnt    <= '0;
      sc_fill    <= 1'b1;
    end else if (valid) begin
      w1_q <= w2_q;
      w2_q <= data;
      if (addr == '0) first_byte <= data;
      if (in_fill_range && (data != first_byte)) sc_fill <= 1'b0;
      if (e0_hit && (e0_cnt != 3'd7)) e0_cnt <= e0_cnt + 3'd1;
      if (c3f_hit && (c3f_cnt != 2'd3)) c3f_cnt <= c3f_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/cart_bs_detect.sv
// Cartridge load controller: tracks download size, latches the extension and,
// when no extension hint exists, scans the ROM to pick a bank-switch scheme.
module cart_bs_detect
  import cart_pkg::*;
#(
  parameter int          ADDR_W    = 15,
  parameter int unsigned E0_MIN    = 4,
  parameter int unsigned SIG3F_MIN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [16:0]       ioctl_addr,
  input  logic [23:0]       ext,
  input  logic              ext_s,
  input  logic [1:0]        sc_mode,
  input  logic [ADDR_W-1:0] console_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic [3:0]        force_bs,
  output logic              sc,
  output logic [16:0]       rom_size,
  output logic              done
);

  localparam logic [16:0] ROM_CAP = 17'(1 << ADDR_W);

  state_t            state_q, state_d;
  logic              dl_q;
  logic              dl_rise, dl_fall;
  logic [23:0]       ext_q;
  logic              ext_s_q;
  logic [1:0]        sc_mode_q;
  logic              scanned_q;
  logic [ADDR_W-1:0] scan_ptr;
  logic [ADDR_W-1:0] scan_last;
  logic              issue_on;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [17:0]       size_cand;
  logic [16:0]       size_next;
  logic              start_load, start_scan, table_hit;
  logic              e0_ok, sig3f_ok, sc_d;
  bs_t               ext_bs, decide_bs;
  logic [2:0]        e0_cnt;
  logic [1:0]        c3f_cnt;
  logic              sc_fill;

  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;
  assign ext_bs    = ext_to_bs(ext_q);
  assign size_cand = {1'b0, ioctl_addr} + 18'd1;
  assign size_next = size_cand[17] ? 17'h1FFFF : size_cand[16:0];
  assign scan_last = (rom_size >= ROM_CAP) ? {ADDR_W{1'b1}} : ADDR_W'(rom_size - 17'd1);
  assign e0_ok     = 32'(e0_cnt) >= E0_MIN;
  assign sig3f_ok  = 32'(c3f_cnt) >= SIG3F_MIN;
  assign busy      = (state_q != ST_IDLE);
  assign rom_addr  = (state_q == ST_SCAN) ? scan_ptr : console_addr;

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    start_scan = 1'b0;
    table_hit  = 1'b0;
    case (state_q)
      ST_IDLE: if (dl_rise) begin
        state_d    = ST_LOAD;
        start_load = 1'b1;
      end
      ST_LOAD: if (dl_fall) begin
        if (ext_bs != BS_NONE) begin
          state_d   = ST_FIN;
          table_hit = 1'b1;
        end else if (rom_size == '0) begin
          state_d = ST_DECIDE;
        end else begin
          state_d    = ST_SCAN;
          start_scan = 1'b1;
        end
      end
      ST_SCAN: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end else if (rd_valid && (rd_addr == scan_last)) begin
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        state_d = ST_FIN;
        if (dl_rise) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end
      end
      ST_FIN: begin
        // A download starting on the result cycle is not lost.
        state_d = ST_IDLE;
        if (dl_rise) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    decide_bs = BS_NONE;
    if (rom_size <= SZ_4K)                                  decide_bs = BS_NONE;
    else if (rom_size == SZ_8K)                             decide_bs = e0_ok ? BS_E0 : (sig3f_ok ? BS_3F : BS_F8);
    else if ((rom_size >= SZ_P2_MIN) && (rom_size <= SZ_P2_MAX)) decide_bs = BS_P2;
    else if (rom_size == SZ_12K)                            decide_bs = BS_FA;
    else if (rom_size == SZ_16K)                            decide_bs = sig3f_ok ? BS_3F : BS_F6;
    else if (rom_size == SZ_32K)                            decide_bs = sig3f_ok ? BS_3F : BS_F4;
  end

  always_comb begin
    case (sc_mode_q)
      2'd0:    sc_d = ext_s_q | (sc_fill & scanned_q & (rom_size >= SZ_8K));
      2'd1:    sc_d = 1'b0;
      default: sc_d = 1'b1;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dl_q      <= 1'b0;
      ext_q     <= '0;
      ext_s_q   <= 1'b0;
      sc_mode_q <= '0;
      scanned_q <= 1'b0;
      scan_ptr  <= '0;
      issue_on  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rom_size  <= '0;
      force_bs  <= '0;
      sc        <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      done    <= 1'b0;

      if (start_load) begin
        rom_size  <= '0;
        ext_q     <= ext;
        ext_s_q   <= ext_s;
        sc_mode_q <= sc_mode;
        scanned_q <= 1'b0;
        issue_on  <= 1'b0;
        rd_valid  <= 1'b0;
      end else if ((state_q == ST_LOAD) && ioctl_wr && (size_next > rom_size)) begin
        rom_size <= size_next;
      end

      if (table_hit) force_bs <= ext_bs;

      if (start_scan) begin
        scan_ptr  <= '0;
        issue_on  <= 1'b1;
        scanned_q <= 1'b1;
      end else if ((state_q == ST_SCAN) && !start_load) begin
        rd_valid <= issue_on;
        rd_addr  <= scan_ptr;
        if (issue_on) begin
          if (scan_ptr == scan_last) issue_on <= 1'b0;
          else                       scan_ptr <= scan_ptr + 1'b1;
        end
      end

      if ((state_q == ST_DECIDE) && !start_load) force_bs <= decide_bs;

      if (state_q == ST_FIN) begin
        done <= 1'b1;
        sc   <= sc_d;
      end
    end
  end

  cart_sig_scan #(
    .ADDR_W (ADDR_W)
  ) u_sig_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_load),
    .valid   (rd_valid && (state_q == ST_SCAN)),
    .addr    (rd_addr),
    .data    (rom_data),
    .e0_cnt  (e0_cnt),
    .c3f_cnt (c3f_cnt),
    .sc_fill (sc_fill)
  );

endmodule

// File: tb/tb_cart_bs_detect.sv
// Bench for cart_bs_detect: ROM model on port B, reference model over the
// image bytes, scoreboard queue checked on every done pulse.
module tb_cart_bs_detect;

  localparam int ADDR_W = 15;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [16:0]       ioctl_addr = '0;
  logic [23:0]       ext = '0;
  logic              ext_s = 1'b0;
  logic [1:0]        sc_mode = '0;
  logic [ADDR_W-1:0] console_addr = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              busy;
  logic [3:0]        force_bs;
  logic              sc;
  logic [16:0]       rom_size;
  logic              done;

  logic [7:0]  mem [MEM_N];
  logic [23:0] ext_tbl [9] = '{".F8", ".F6", ".FE", ".E0", ".3F", ".F4", ".P2", ".FA", ".CV"};

  typedef struct {
    logic [3:0]  bs;
    logic        sc;
    logic [16:0] size;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  cart_bs_detect #(
    .ADDR_W    (ADDR_W),
    .E0_MIN    (4),
    .SIG3F_MIN (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ext            (ext),
    .ext_s          (ext_s),
    .sc_mode        (sc_mode),
    .console_addr   (console_addr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .busy           (busy),
    .force_bs       (force_bs),
    .sc             (sc),
    .rom_size       (rom_size),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Port-B RAM: one cycle read latency.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (done === 1'b1)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("force_bs", 32'(force_bs), 32'(mon_e.bs));
        check("sc", 32'(sc), 32'(mon_e.sc));
        check("rom_size", 32'(rom_size), 32'(mon_e.size));
      end
    end
  end

  // Reference model, straight from the detection rules over the image bytes.
  function automatic exp_t model(input int size, input logic [23:0] e, input logic es,
                                 input logic [1:0] scm, output int lat, output bit scanned);
    exp_t r;
    int   idx = 0;
    int   len, ne0, n3f;
    bit   fill = 1;
    r.bs = 0; r.size = 17'(size); scanned = 0;
    for (int i = 0; i < 9; i++) if (e == ext_tbl[i]) idx = i + 1;
    if (idx != 0) begin
      r.bs = 4'(idx); lat = 2;
    end else if (size == 0) begin
      lat = 3;
    end else begin
      scanned = 1;
      len = (size > MEM_N) ? MEM_N : size;
      lat = len + 4;
      ne0 = 0; n3f = 0;
      for (int i = 0; i + 2 < len; i++)
        if ((mem[i] == 8'h8D || mem[i] == 8'hAD || mem[i] == 8'h2C) &&
            mem[i+1] >= 8'hE0 && mem[i+1] <= 8'hF7 && mem[i+2] == 8'h1F) ne0++;
      for (int i = 0; i + 1 < len; i++)
        if (mem[i] == 8'h85 && mem[i+1] == 8'h3F) n3f++;
      for (int i = 1; i < len && i < 128; i++) if (mem[i] != mem[0]) fill = 0;
      if (size <= 4096)                      r.bs = 0;
      else if (size == 8192)                 r.bs = (ne0 >= 4) ? 4 : ((n3f >= 2) ? 5 : 1);
      else if (size >= 10240 && size <= 10495) r.bs = 7;
      else if (size == 12288)                r.bs = 8;
      else if (size == 16384)                r.bs = (n3f >= 2) ? 5 : 2;
      else if (size == 32768)                r.bs = (n3f >= 2) ? 5 : 6;
    end
    if (scm == 2'd0)      r.sc = es | (fill && size >= 8192 && scanned);
    else if (scm == 2'd1) r.sc = 0;
    else                  r.sc = 1;
    return r;
  endfunction

  // Random image without 0x85/0x1F, so signatures exist only where planted.
  task automatic make_image(input int size, input int n_e0, input int n_3f, input bit ff_head);
    logic [7:0] b;
    int p;
    for (int i = 0; i < size && i < MEM_N; i++) begin
      b = 8'($urandom);
      if (b == 8'h85 || b == 8'h1F) b = b ^ 8'h01;
      mem[i] = b;
    end
    for (int k = 0; k < n_e0; k++) begin
      p = 300 + k * 40;
      if (p + 2 < size) begin
        case ($urandom_range(0, 2))
          0: mem[p] = 8'h8D;
          1: mem[p] = 8'hAD;
          default: mem[p] = 8'h2C;
        endcase
        mem[p+1] = 8'($urandom_range(8'hE0, 8'hF7));
        mem[p+2] = 8'h1F;
      end
    end
    for (int k = 0; k < n_3f; k++) begin
      p = 1000 + k * 30;
      if (p + 1 < size) begin
        mem[p] = 8'h85; mem[p+1] = 8'h3F;
      end
    end
    if (ff_head) for (int i = 0; i < 128; i++) mem[i] = 8'hFF;
  endtask

  task automatic start_load(input int size, input logic [23:0] e, input logic es, input logic [1:0] scm);
    int nw, pos_last;
    @(negedge clk);
    ext = e; ext_s = es; sc_mode = scm; ioctl_download = 1'b1;
    @(negedge clk);
    // Scramble the hint inputs: the values latched at download start must be used.
    ext = 24'($urandom); ext_s = 1'($urandom); sc_mode = 2'($urandom);
    if (size > 0) begin
      nw = 12;
      pos_last = $urandom_range(0, nw - 1);
      for (int i = 0; i < nw; i++) begin
        ioctl_wr = 1'b1;
        ioctl_addr = (i == pos_last) ? 17'(size - 1) : 17'($urandom_range(0, size - 1));
        @(negedge clk);
        ioctl_wr = 1'b0;
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end
    console_addr = ADDR_W'($urandom);
    #1;
    check("load_busy", 32'(busy), 32'd1);
    check("load_rom_addr", 32'(rom_addr), 32'(console_addr));
    check("load_rom_size", 32'(rom_size), 32'(size));
  endtask

  task automatic finish_load(input int size, input logic [23:0] e, input logic es, input logic [1:0] scm);
    exp_t ex;
    int   lat, n, walk_err, busy_err, len;
    bit   scanned;
    ex = model(size, e, es, scm, lat, scanned);
    len = (size > MEM_N) ? MEM_N : size;
    sb_q.push_back(ex);
    ioctl_download = 1'b0;
    console_addr = ADDR_W'($urandom);
    n = 0; walk_err = 0; busy_err = 0;
    do begin
      @(negedge clk);
      n++;
      if (done !== 1'b1) begin
        if (busy !== 1'b1) busy_err++;
        if (scanned && n <= len && 32'(rom_addr) != 32'(n - 1)) walk_err++;
      end
    end while (done !== 1'b1 && n < lat + 50);
    check("done_latency", 32'(n), 32'(lat));
    check("busy_while_working", 32'(busy_err), 32'd0);
    if (scanned) check("scan_addr_walk", 32'(walk_err), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    console_addr = ADDR_W'($urandom);
    #1;
    check("idle_rom_addr", 32'(rom_addr), 32'(console_addr));
    ioctl_wr = 1'b1; ioctl_addr = 17'h1FFFF;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    check("idle_wr_ignored", 32'(rom_size), 32'(size));
  endtask

  task automatic full_load(input int size, input logic [23:0] e, input logic es, input logic [1:0] scm);
    start_load(size, e, es, scm);
    finish_load(size, e, es, scm);
  endtask

  initial begin
    #(10 * 99000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

  initial begin
    int sizes [8] = '{0, 1, 3000, 4096, 5000, 8192, 10240, 12288};
    int sz, k;
    logic [23:0] e;
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_force_bs", 32'(force_bs), 32'd0);
    check("rst_sc", 32'(sc), 32'd0);
    check("rst_rom_size", 32'(rom_size), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Extension hint: no scan.
    make_image(8192, 0, 0, 0);
    full_load(8192, ".F8", 1'b0, 2'd0);

    // E0 by signature count.
    make_image(8192, 5, 0, 0);
    full_load(8192, "BIN", 1'b0, 2'd0);

    // 3F at 16K, SuperChip by fill pattern.
    make_image(16384, 0, 2, 1);
    full_load(16384, "BIN", 1'b0, 2'd0);

    // Small image, SuperChip forced on.
    make_image(4096, 0, 0, 0);
    full_load(4096, "BIN", 1'b0, 2'd2);

    // Largest P2 size.
    make_image(10495, 0, 0, 0);
    full_load(10495, "BIN", 1'b0, 2'd0);

    // Abort mid-scan: first image would be 3F, second has one 3F signature only.
    make_image(8192, 0, 3, 0);
    start_load(8192, "BIN", 1'b0, 2'd0);
    ioctl_download = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_scan_busy", 32'(busy), 32'd1);
    check("abort_scan_addr", 32'(rom_addr), 32'd299);
    make_image(8192, 0, 1, 0);
    full_load(8192, "BIN", 1'b0, 2'd2);

    // Reset during a scan: outputs clear, no done afterwards.
    make_image(1024, 0, 0, 0);
    start_load(1024, "BIN", 1'b0, 2'd3);
    ioctl_download = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_force_bs", 32'(force_bs), 32'd0);
    check("midrst_sc", 32'(sc), 32'd0);
    check("midrst_rom_size", 32'(rom_size), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (1200) @(negedge clk);

    // Randomized loads.
    for (int t = 0; t < 3; t++) begin
      sz = sizes[$urandom_range(0, 7)];
      k = $urandom_range(0, 9);
      e = (k == 9) ? 24'("BIN") : ext_tbl[k];
      make_image(sz, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      full_load(sz, e, 1'($urandom), 2'($urandom));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
